sobel_frame_ctrl: RTL and testbench

//  Frame-synchronous controller for the Sobel edge-filter datapath. Turns debounced push-buttons into

---
 rtl/sobel_frame_ctrl_pkg.sv | 12 +
 rtl/sobel_frame_ctrl_debounce.sv | 33 +++
 rtl/sobel_frame_ctrl.sv | 114 +++++++++++
 tb/tb_sobel_frame_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sobel_frame_ctrl_pkg.sv
// cam_pkg: shared mode/state encodings and frame constants for the camera pipeline
package cam_pkg;
   localparam logic [1:0] MODE_CAM   = 2'd0;
   localparam logic [1:0] MODE_GRAY  = 2'd1;
   localparam logic [1:0] MODE_SOBEL = 2'd2;
   localparam int FRAME_W = 320;
   localparam int FRAME_H = 240;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;
   function automatic logic [1:0] next_mode(input logic [1:0] m);
      return (m == MODE_SOBEL) ? MODE_CAM : m + 2'd1;
   endfunction
endpackage

// File: rtl/sobel_frame_ctrl_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and one-shot press pulse
module btn_debounce #(
   parameter int DEB_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   logic s1, s2, level;
   logic [CW-1:0] cnt;
   // accept a new level only after it has differed from the accepted one for DEB_CYCLES cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         level <= 1'b0;
         press <= 1'b0;
         cnt   <= '0;
      end else begin
         s1    <= btn;
         s2    <= s1;
         press <= 1'b0;
         if (s2 == level) cnt <= '0;
         else if (cnt == CW'(DEB_CYCLES - 1)) begin
            cnt   <= '0;
            level <= s2;
            press <= s2;
         end else cnt <= cnt + CW'(1);
      end
   end
endmodule

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: button-driven shadow config applied at frame boundaries, Sobel enable/drain FSM
module sobel_frame_ctrl import cam_pkg::*; #(
   parameter int          DEB_CYCLES = 250000,
   parameter logic [10:0] THR_INIT   = 11'd100,
   parameter logic [10:0] THR_STEP   = 11'd16,
   parameter logic [10:0] THR_MAX    = 11'd1020,
   parameter int          DRAIN_LAT  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_mode,
   input  logic        vsync,
   input  logic        active_area,
   input  logic        sobel_ready,
   output logic        filter_enable,
   output logic [10:0] threshold,
   output logic [1:0]  out_sel,
   output logic [7:0]  frame_count,
   output logic        cfg_update
);
   localparam int DW = $clog2(DRAIN_LAT + 1);
   logic p_up, p_down, p_mode;
   logic vs_s1, vs_s2, vs_d, vs_rise;
   logic [10:0] shadow_thr, thr_up, thr_dn;
   logic [11:0] up_sum;
   logic [1:0] shadow_mode, target_mode;
   logic [DW-1:0] dcnt, dcnt_nx;
   state_t state;
   logic unused_active;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up   (.clk(clk), .rst(rst), .btn(btn_up),   .press(p_up));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_down (.clk(clk), .rst(rst), .btn(btn_down), .press(p_down));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (.clk(clk), .rst(rst), .btn(btn_mode), .press(p_mode));

   // the filter gates itself on active video, so the controller does not need it
   assign unused_active = active_area;
   assign vs_rise = vs_s2 & ~vs_d;
   assign up_sum  = {1'b0, shadow_thr} + {1'b0, THR_STEP};
   assign thr_up  = (up_sum > {1'b0, THR_MAX}) ? THR_MAX : up_sum[10:0];
   assign thr_dn  = (shadow_thr < THR_STEP) ? 11'd0 : shadow_thr - THR_STEP;
   assign dcnt_nx = sobel_ready ? '0 : dcnt + DW'(1);

   // synchronize vsync and keep one extra stage for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_s1 <= 1'b0;
         vs_s2 <= 1'b0;
         vs_d  <= 1'b0;
      end else begin
         vs_s1 <= vsync;
         vs_s2 <= vs_s1;
         vs_d  <= vs_s2;
      end
   end

   // shadow settings follow button presses; opposing up/down presses cancel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_thr  <= THR_INIT;
         shadow_mode <= MODE_CAM;
      end else begin
         if (p_up && !p_down) shadow_thr <= thr_up;
         else if (p_down && !p_up) shadow_thr <= thr_dn;
         if (p_mode) shadow_mode <= next_mode(shadow_mode);
      end
   end

   // frame-boundary apply plus IDLE/RUN/DRAIN control of filter enable and output mux
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         filter_enable <= 1'b0;
         threshold     <= THR_INIT;
         out_sel       <= MODE_CAM;
         frame_count   <= 8'd0;
         cfg_update    <= 1'b0;
         target_mode   <= MODE_CAM;
         dcnt          <= '0;
      end else begin
         cfg_update <= 1'b0;
         if (vs_rise) begin
            frame_count <= frame_count + 8'd1;
            threshold   <= shadow_thr;
            cfg_update  <= (shadow_thr != threshold) || (state != ST_DRAIN && shadow_mode != out_sel);
         end
         case (state)
            ST_IDLE: if (vs_rise) begin
               if (shadow_mode == MODE_SOBEL) begin
                  state         <= ST_RUN;
                  filter_enable <= 1'b1;
                  out_sel       <= MODE_SOBEL;
               end else out_sel <= shadow_mode;
            end
            ST_RUN: if (vs_rise && shadow_mode != MODE_SOBEL) begin
               state         <= ST_DRAIN;
               filter_enable <= 1'b0;
               target_mode   <= shadow_mode;
               dcnt          <= '0;
            end
            ST_DRAIN: begin
               dcnt <= dcnt_nx;
               if (dcnt_nx == DW'(DRAIN_LAT)) begin
                  state   <= ST_IDLE;
                  out_sel <= target_mode;
                  dcnt    <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: directed + random stimulus against a frame-level behavioural model
module tb_sobel_frame_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic btn_up = 1'b0, btn_down = 1'b0, btn_mode = 1'b0, vsync = 1'b0;
   logic active_area = 1'b0, sobel_ready = 1'b1;
   logic filter_enable, cfg_update;
   logic [10:0] threshold;
   logic [1:0] out_sel;
   logic [7:0] frame_count;
   int total = 0, bad = 0;
   int m_sthr, m_thr, m_smode, m_osel, m_st, m_fc, m_fe, m_target, m_lows;
   int pat[13] = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

   sobel_frame_ctrl #(.DEB_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_mode(btn_mode),
      .vsync(vsync), .active_area(active_area), .sobel_ready(sobel_ready),
      .filter_enable(filter_enable), .threshold(threshold), .out_sel(out_sel),
      .frame_count(frame_count), .cfg_update(cfg_update)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_sthr = 100; m_thr = 100; m_smode = 0; m_osel = 0; m_st = 0;
      m_fc = 0; m_fe = 0; m_target = 0; m_lows = 0;
   endtask

   task automatic model_press(input logic [2:0] mask);
      if (mask[0] && !mask[1]) m_sthr = (m_sthr + 16 > 1020) ? 1020 : m_sthr + 16;
      else if (mask[1] && !mask[0]) m_sthr = (m_sthr < 16) ? 0 : m_sthr - 16;
      if (mask[2]) m_smode = (m_smode + 1) % 3;
   endtask

   task automatic press(input logic [2:0] mask);
      {btn_mode, btn_down, btn_up} = mask;
      tick(10);
      {btn_mode, btn_down, btn_up} = 3'b000;
      tick(10);
      model_press(mask);
      m_lows = 0;
   endtask

   task automatic frame();
      int exp_cfg;
      m_lows = 0;
      vsync = 1'b1;
      tick(2);
      chk("thr_hold", threshold, m_thr);
      chk("osel_hold", out_sel, m_osel);
      chk("cfg_pre", cfg_update, 0);
      tick(1);
      exp_cfg = (m_sthr != m_thr || (m_st != 2 && m_smode != m_osel)) ? 1 : 0;
      m_fc = (m_fc + 1) % 256;
      m_thr = m_sthr;
      if (m_st == 0) begin
         if (m_smode == 2) begin m_st = 1; m_osel = 2; m_fe = 1; end
         else m_osel = m_smode;
      end else if (m_st == 1 && m_smode != 2) begin
         m_st = 2; m_fe = 0; m_target = m_smode;
      end
      chk("thr", threshold, m_thr);
      chk("osel", out_sel, m_osel);
      chk("fe", filter_enable, m_fe);
      chk("fc", frame_count, m_fc);
      chk("cfg", cfg_update, exp_cfg);
      vsync = 1'b0;
      tick(1);
      chk("cfg_post", cfg_update, 0);
      tick(2);
   endtask

   task automatic drain_cycle(input int r);
      sobel_ready = r[0];
      tick(1);
      if (m_st == 2) begin
         m_lows = r[0] ? 0 : m_lows + 1;
         if (m_lows == 8) begin m_st = 0; m_osel = m_target; end
      end
      chk("drain_osel", out_sel, m_osel);
      chk("drain_fe", filter_enable, m_fe);
   endtask

   initial begin
      model_reset();
      tick(2);
      chk("rst_fe", filter_enable, 0);
      chk("rst_thr", threshold, 100);
      chk("rst_osel", out_sel, 0);
      chk("rst_fc", frame_count, 0);
      chk("rst_cfg", cfg_update, 0);
      rst = 1'b0;
      tick(2);
      // short glitch must be ignored, stable press accepted
      btn_up = 1'b1;
      tick(3);
      btn_up = 1'b0;
      tick(10);
      frame();
      press(3'b001);
      frame();
      chk("thr_116", threshold, 116);
      // saturation at both ends, cancelling presses
      repeat (70) press(3'b001);
      frame();
      chk("thr_max", threshold, 1020);
      repeat (70) press(3'b010);
      frame();
      chk("thr_zero", threshold, 0);
      press(3'b011);
      frame();
      press(3'b001);
      press(3'b011);
      frame();
      // enter Sobel mode
      press(3'b100);
      press(3'b100);
      frame();
      chk("run_osel", out_sel, 2);
      chk("run_fe", filter_enable, 1);
      // leave Sobel mode through a drain with trailing ready pulses
      press(3'b100);
      frame();
      foreach (pat[i]) drain_cycle(pat[i]);
      chk("drain_done", out_sel, 0);
      sobel_ready = 1'b1;
      tick(2);
      // reset in the middle of a RUN frame
      press(3'b100);
      press(3'b100);
      press(3'b001);
      frame();
      tick(3);
      #2 rst = 1'b1;
      #1;
      chk("mrst_fe", filter_enable, 0);
      chk("mrst_thr", threshold, 100);
      chk("mrst_osel", out_sel, 0);
      chk("mrst_fc", frame_count, 0);
      chk("mrst_cfg", cfg_update, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      tick(2);
      // frame counter wrap
      repeat (256) frame();
      chk("fc_wrap", frame_count, 0);
      // press lands on the vs_rise cycle: applied one frame later
      btn_up = 1'b1;
      tick(4);
      frame();
      btn_up = 1'b0;
      tick(10);
      model_press(3'b001);
      chk("simul_hold", threshold, 100);
      frame();
      chk("simul_apply", threshold, 116);
      // random presses and frames
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            frame();
            if (m_st == 2) begin
               repeat (12) drain_cycle(int'($urandom_range(0, 1)));
               for (int k = 0; k < 10 && m_st == 2; k++) drain_cycle(0);
               sobel_ready = 1'b1;
               tick(1);
               m_lows = 0;
            end
         end else press(3'($urandom_range(1, 7)));
      end
      frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
